program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter NB, default 32: width of PC, jump/branch targets and cycle counter.
REQ-002 Parameter N_OF_INSTRUCTIONS, default 64: instruction memory depth in words; valid byte addresses 0 .. 4*N_OF_INSTRUCTIONS-4.
REQ-003 i_clock  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  one clock; reset is synchronous and active-low (state cleared on rising edge of i_clock while i_reset=0).
REQ-005 i_start  input  1  debug unit request to leave IDLE and begin execution.
REQ-006 i_step_mode  input  1  1 = single-step execution, 0 = continuous; sampled only in IDLE.
REQ-007 i_step  input  1  step request level from debug unit; one advance per rising edge.
REQ-008 i_stall  input  1  hazard stall; PC held while 1.
REQ-009 i_jump / i_jump_target  input  1 / NB  jump redirect and target byte address.
REQ-010 i_branch_taken / i_branch_target  input  1 / NB  taken-branch redirect and target byte address.
REQ-011 i_halt_detected  input  1  HALT instruction present at current PC.
REQ-012 o_pc  output  NB  current fetch byte address, to instruction memory i_pc_address.
REQ-013 o_pc_plus_4  output  NB  o_pc + 4, combinational, for link/IF-ID latch.
REQ-014 o_advance  output  1  combinational; 1 in the cycle PC updates, downstream IF/ID register latches.
REQ-015 o_halted  output  1  registered; 1 while in HALTED.
REQ-016 o_state  output  2  registered FSM state, for debug unit.
REQ-017 o_cycle_count  output  NB  registered count of advances since reset.

Function
REQ-018 FSM states IDLE, RUN, WAIT_STEP, HALTED; encoding 00, 01, 10, 11.
REQ-019 IDLE: PC held; i_start=1 -> RUN if i_step_mode=0, WAIT_STEP if 1; i_halt_detected, i_stall, redirects ignored.
REQ-020 Step edge = i_step=1 this cycle and 0 previous cycle (registered history, cleared by reset); level held N cycles gives exactly one edge.
REQ-021 advance_req = RUN, or WAIT_STEP with step edge; o_advance = advance_req & !i_stall & !i_halt_detected & !out_of_range.
REQ-022 next_pc priority: i_jump -> i_jump_target; else i_branch_taken -> i_branch_target; else o_pc + 4; bits [1:0] forced to 0.
REQ-023 On o_advance=1, o_pc <= next_pc and o_cycle_count <= o_cycle_count + 1 (wraps modulo 2^NB).
REQ-024 i_stall=1: PC and counter held, redirects not consumed; redirect source holds request until a cycle with o_advance=1.
REQ-025 A step edge coinciding with i_stall=1 is lost; WAIT_STEP requires a new edge.
REQ-026 out_of_range = next_pc >= 4*N_OF_INSTRUCTIONS; with advance_req and !i_stall -> HALTED, PC not updated (no wrap-around).
REQ-027 i_halt_detected=1 in RUN or WAIT_STEP (regardless of i_stall or step edge) -> HALTED next cycle, PC held at HALT address, o_advance=0.
REQ-028 HALTED: all inputs ignored; exit only via reset; o_halted=1 from first cycle in HALTED.
REQ-029 i_step_mode changes outside IDLE have no effect.

Reset
REQ-030 While i_reset=0 on a rising edge: state IDLE, o_pc=0, o_cycle_count=0, step history 0, o_halted=0; o_advance=0 in IDLE.
REQ-031 Reset mid-RUN or mid-HALTED has the same result in one cycle; no pending redirect or step survives.

Structure
REQ-032 Shared pipeline package holds state encoding constants (IDLE/RUN/WAIT_STEP/HALTED) and PC_INCREMENT=4.
REQ-033 One sub-module, edge_detector (rising-edge pulse, synchronous active-low reset), used for i_step; everything else in program_counter.

Verification
REQ-034 Reset, i_start=1, i_step_mode=0, no stall -> o_pc 0,4,8,12 on consecutive cycles, o_cycle_count=3 after third advance.
REQ-035 RUN at o_pc=0x10, i_jump=1 target 0x22 and i_branch_taken=1 target 0x08 same cycle -> o_pc=0x20 next cycle.
REQ-036 Step mode, i_step held high 5 cycles, then low, then high 1 cycle -> exactly two advances, o_pc=8.
REQ-037 RUN at 0x0C, i_stall=1 for 3 cycles with i_branch_taken target 0x30 held -> o_pc stays 0x0C, then 0x30 the cycle after stall drops.
REQ-038 N_OF_INSTRUCTIONS=4, RUN from 0 -> o_pc stops at 0x0C, o_halted=1, o_state=11; i_halt_detected at 0x08 instead -> o_pc held 0x08, HALTED.
REQ-039 i_reset=0 for one cycle while HALTED -> o_pc=0, o_state=00, o_halted=0, o_cycle_count=0.

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM state encoding and PC stride.
package program_counter_pkg;

   // Fetch FSM states. The debug unit reads this encoding directly on o_state.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_RUN       = 2'b01,
      ST_WAIT_STEP = 2'b10,
      ST_HALTED    = 2'b11
   } pc_state_e;

   // Instructions are one 32-bit word wide, so sequential fetch moves by 4 bytes.
   localparam int unsigned PC_INCREMENT = 4;

   // Tells the FSM whether a state may move the PC.
   function automatic logic is_executing(input pc_state_e state);
      return (state == ST_RUN) || (state == ST_WAIT_STEP);
   endfunction

endpackage

// File: rtl/program_counter_edge_detector.sv
// Rising-edge pulse generator: one-cycle pulse when the input goes from 0 to 1.
module edge_detector (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_signal,
   output logic o_rise
);

   logic level_d;
   logic level_q;

   // The history follows the input level every cycle.
   always_comb begin
      level_d = i_signal;
   end

   // Store the previous level; reset clears it so a level held through reset counts as a new edge.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_d;
      end
   end

   assign o_rise = i_signal & ~level_q;

endmodule

// File: rtl/program_counter.sv
// Program counter with debug-controlled run/single-step FSM, halt detection and range guard.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int NB                = 32,
   parameter int N_OF_INSTRUCTIONS = 64
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic          i_step_mode,
   input  logic          i_step,
   input  logic          i_stall,
   input  logic          i_jump,
   input  logic [NB-1:0] i_jump_target,
   input  logic          i_branch_taken,
   input  logic [NB-1:0] i_branch_target,
   input  logic          i_halt_detected,
   output logic [NB-1:0] o_pc,
   output logic [NB-1:0] o_pc_plus_4,
   output logic          o_advance,
   output logic          o_halted,
   output logic [1:0]    o_state,
   output logic [NB-1:0] o_cycle_count
);

   // First byte address past the end of instruction memory, one bit wider so it never overflows.
   localparam logic [NB:0]   PC_LIMIT   = (NB+1)'(PC_INCREMENT * N_OF_INSTRUCTIONS);
   // Clears the two byte-offset bits so the PC always stays word aligned.
   localparam logic [NB-1:0] ALIGN_MASK = ~NB'(3);

   pc_state_e     state_d;
   pc_state_e     state_q;
   logic [NB-1:0] pc_d;
   logic [NB-1:0] pc_q;
   logic [NB-1:0] cycle_count_d;
   logic [NB-1:0] cycle_count_q;
   logic          halted_d;
   logic          halted_q;

   logic          step_rise;
   logic [NB-1:0] pc_plus_4;
   logic [NB-1:0] next_pc;
   logic          out_of_range;
   logic          advance_req;
   logic          advance;

   edge_detector u_step_edge (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_signal (i_step),
      .o_rise   (step_rise)
   );

   // Choose the next fetch address (jump beats branch beats sequential) and guard the memory range.
   always_comb begin
      pc_plus_4 = pc_q + NB'(PC_INCREMENT);
      next_pc   = pc_plus_4;
      if (i_jump) begin
         next_pc = i_jump_target;
      end else if (i_branch_taken) begin
         next_pc = i_branch_target;
      end
      next_pc      = next_pc & ALIGN_MASK;
      out_of_range = ({1'b0, next_pc} >= PC_LIMIT);
   end

   // Decide whether this cycle moves the PC; a stall, a HALT or a bad target blocks it.
   always_comb begin
      advance_req = (state_q == ST_RUN) || ((state_q == ST_WAIT_STEP) && step_rise);
      advance     = advance_req && !i_stall && !i_halt_detected && !out_of_range;
   end

   // Next-state and datapath update for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cycle_count_d = cycle_count_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = i_step_mode ? ST_WAIT_STEP : ST_RUN;
            end
         end
         ST_RUN, ST_WAIT_STEP: begin
            if (i_halt_detected) begin
               state_d = ST_HALTED;
            end else if (advance_req && !i_stall && out_of_range) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (advance && is_executing(state_q)) begin
         pc_d          = next_pc;
         cycle_count_d = cycle_count_q + NB'(1);
      end

      halted_d = (state_d == ST_HALTED);
   end

   // State, PC, counter and halted flag registers with synchronous active-low reset.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         cycle_count_q <= '0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cycle_count_q <= cycle_count_d;
         halted_q      <= halted_d;
      end
   end

   assign o_pc          = pc_q;
   assign o_pc_plus_4   = pc_plus_4;
   assign o_advance     = advance;
   assign o_halted      = halted_q;
   assign o_state       = state_q;
   assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed scenarios with hand-computed PC/count sequences.
module tb_program_counter;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_start = 1'b0;
   logic        i_step_mode = 1'b0;
   logic        i_step = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_jump = 1'b0;
   logic [31:0] i_jump_target = '0;
   logic        i_branch_taken = 1'b0;
   logic [31:0] i_branch_target = '0;
   logic        i_halt_detected = 1'b0;

   logic [31:0] pc, pc_plus_4, cycle_count;
   logic        advance, halted;
   logic [1:0]  state;

   logic [31:0] s_pc, s_pc_plus_4, s_cycle_count;
   logic        s_advance, s_halted;
   logic [1:0]  s_state;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] count;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic pending = 1'b0;
   int   checks = 0;
   int   failures = 0;

   program_counter #(.NB(32), .N_OF_INSTRUCTIONS(64)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
      .i_step(i_step), .i_stall(i_stall), .i_jump(i_jump), .i_jump_target(i_jump_target),
      .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
      .i_halt_detected(i_halt_detected), .o_pc(pc), .o_pc_plus_4(pc_plus_4),
      .o_advance(advance), .o_halted(halted), .o_state(state), .o_cycle_count(cycle_count)
   );

   program_counter #(.NB(32), .N_OF_INSTRUCTIONS(4)) dut_small (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
      .i_step(i_step), .i_stall(i_stall), .i_jump(i_jump), .i_jump_target(i_jump_target),
      .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
      .i_halt_detected(i_halt_detected), .o_pc(s_pc), .o_pc_plus_4(s_pc_plus_4),
      .o_advance(s_advance), .o_halted(s_halted), .o_state(s_state), .o_cycle_count(s_cycle_count)
   );

   always #5 i_clock = ~i_clock;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic push_expected(input logic [31:0] exp_pc, input logic [31:0] exp_count);
      exp_t e;
      e.pc    = exp_pc;
      e.count = exp_count;
      sb_q.push_back(e);
   endtask

   task automatic apply_stimulus(input logic start, input logic step_mode, input logic step,
                                 input logic stall, input logic jump, input logic [31:0] jump_target,
                                 input logic branch, input logic [31:0] branch_target, input logic halt);
      i_start         = start;
      i_step_mode     = step_mode;
      i_step          = step;
      i_stall         = stall;
      i_jump          = jump;
      i_jump_target   = jump_target;
      i_branch_taken  = branch;
      i_branch_target = branch_target;
      i_halt_detected = halt;
   endtask

   task automatic do_reset(input string tag);
      i_reset = 1'b0;
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      i_reset = 1'b1;
      @(negedge i_clock);
      check_output({tag, "_pc"}, pc, 32'h0);
      check_output({tag, "_pc_plus_4"}, pc_plus_4, 32'h4);
      check_output({tag, "_state"}, {30'd0, state}, 32'h0);
      check_output({tag, "_halted"}, {31'd0, halted}, 32'h0);
      check_output({tag, "_count"}, cycle_count, 32'h0);
      check_output({tag, "_advance"}, {31'd0, advance}, 32'h0);
      tick();
   endtask

   // Monitor: one cycle after the DUT signals an advance, the new PC and count must match the queue head.
   always @(negedge i_clock) begin
      if (pending) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected_advance actual_pc=0x%0h expected=no advance", pc);
         end else begin
            mon_e = sb_q.pop_front();
            check_output("sb_pc", pc, mon_e.pc);
            check_output("sb_count", cycle_count, mon_e.count);
         end
      end
      pending = advance && i_reset;
   end

   initial begin
      // Reset state
      do_reset("reset0");

      // Continuous run: 0,4,8,12 with three advances
      push_expected(32'h4, 1);
      push_expected(32'h8, 2);
      push_expected(32'hC, 3);
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      do_reset("reset_run");

      // Jump beats branch, target low bits dropped; small memory halts at 0x0C meanwhile
      push_expected(32'h4, 1);
      push_expected(32'h8, 2);
      push_expected(32'hC, 3);
      push_expected(32'h10, 4);
      push_expected(32'h20, 5);
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick(); tick();
      apply_stimulus(0, 0, 0, 0, 1, 32'h22, 1, 32'h08, 0);
      tick();
      i_reset = 1'b0;
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge i_clock);
      check_output("small_range_pc", s_pc, 32'hC);
      check_output("small_range_halted", {31'd0, s_halted}, 32'h1);
      check_output("small_range_state", {30'd0, s_state}, 32'h3);
      check_output("small_range_count", s_cycle_count, 32'h3);
      check_output("small_range_pc_plus_4", s_pc_plus_4, 32'h10);
      check_output("small_range_advance", {31'd0, s_advance}, 32'h0);
      do_reset("reset_redirect");

      // Single step: long pulse gives one advance, short pulse another; step_mode change ignored
      push_expected(32'h4, 1);
      push_expected(32'h8, 2);
      apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick(); tick(); tick();
      i_step = 1'b0;
      tick();
      i_step = 1'b1;
      tick();
      i_step = 1'b0;
      tick(); tick(); tick();
      @(negedge i_clock);
      check_output("step_pc", pc, 32'h8);
      check_output("step_count", cycle_count, 32'h2);
      check_output("step_state", {30'd0, state}, 32'h2);
      do_reset("reset_step");

      // Stall holds PC at 0x0C with a pending branch, branch taken once stall drops
      push_expected(32'h4, 1);
      push_expected(32'h8, 2);
      push_expected(32'hC, 3);
      push_expected(32'h30, 4);
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      apply_stimulus(0, 0, 0, 1, 0, 0, 1, 32'h30, 0);
      tick(); tick();
      @(negedge i_clock);
      check_output("stall_pc", pc, 32'hC);
      check_output("stall_advance", {31'd0, advance}, 32'h0);
      check_output("stall_count", cycle_count, 32'h3);
      tick();
      i_stall = 1'b0;
      tick();
      do_reset("reset_stall");

      // HALT at 0x08: PC held, inputs ignored, then one-cycle reset clears everything
      push_expected(32'h4, 1);
      push_expected(32'h8, 2);
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      i_halt_detected = 1'b1;
      tick();
      apply_stimulus(1, 0, 1, 0, 1, 32'h40, 0, 0, 0);
      tick(); tick();
      @(negedge i_clock);
      check_output("halt_pc", pc, 32'h8);
      check_output("halt_state", {30'd0, state}, 32'h3);
      check_output("halt_halted", {31'd0, halted}, 32'h1);
      check_output("halt_count", cycle_count, 32'h2);
      check_output("halt_advance", {31'd0, advance}, 32'h0);
      check_output("halt_small_pc", s_pc, 32'h8);
      check_output("halt_small_halted", {31'd0, s_halted}, 32'h1);
      tick();
      i_reset = 1'b0;
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      i_reset = 1'b1;
      @(negedge i_clock);
      check_output("halt_reset_pc", pc, 32'h0);
      check_output("halt_reset_state", {30'd0, state}, 32'h0);
      check_output("halt_reset_halted", {31'd0, halted}, 32'h0);
      check_output("halt_reset_count", cycle_count, 32'h0);
      tick(); tick(); tick();

      // Any expected advance never seen is a failure
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         checks++;
         failures++;
         $display("[TB] FAIL sb_missing_advance actual=none expected_pc=0x%0h expected_count=%0d",
                  mon_e.pc, mon_e.count);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
